// File: rtl/drive_seq_pkg.sv
// Shared state encoding and timer width for the drive sequencer.
package drive_seq_pkg;

  localparam int unsigned TIMER_W = 16;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFwd   = 3'd1,
    StBrake = 3'd2,
    StRev   = 3'd3,
    StTurn  = 3'd4,
    StStall = 3'd5
  } drive_state_e;

  function automatic logic is_driving(drive_state_e s);
    return (s == StFwd) || (s == StRev) || (s == StTurn);
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running prescaler: one-cycle tick every CLK_HZ/1000 clocks.
module ms_tick_gen #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic iCLK,
  input  logic iRST_n,
  output logic oTick
);

  localparam int unsigned Div  = CLK_HZ / 1000;
  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign oTick = (cnt_q == CntW'(Div - 1));

  always_comb begin
    cnt_d = oTick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/drive_sequencer.sv
// Obstacle-avoidance sequencer: timed FWD/BRAKE/REV/TURN phases driving both motor channels.
module drive_sequencer
  import drive_seq_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned DIST_W     = 33,
  parameter int unsigned NEAR_CM    = 20,
  parameter int unsigned FAR_CM     = 25,
  parameter int unsigned BRAKE_MS   = 100,
  parameter int unsigned REVERSE_MS = 3200,
  parameter int unsigned TURN_MS    = 800,
  parameter int unsigned STALE_MS   = 200
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic              iEnable,
  input  logic              iTurnMode,
  input  logic [DIST_W-1:0] iDistance,
  input  logic              iDistValid,
  output logic              oDir1,
  output logic              oDir2,
  output logic              oRun,
  output logic [2:0]        oState,
  output logic              oStale
);

  localparam logic [TIMER_W-1:0] BrakeT = TIMER_W'(BRAKE_MS);
  localparam logic [TIMER_W-1:0] RevT   = TIMER_W'(REVERSE_MS);
  localparam logic [TIMER_W-1:0] TurnT  = TIMER_W'(TURN_MS);
  localparam logic [TIMER_W-1:0] StaleT = TIMER_W'(STALE_MS);

  function automatic logic [TIMER_W-1:0] dwell(drive_state_e s);
    case (s)
      StBrake: return BrakeT;
      StRev:   return RevT;
      StTurn:  return TurnT;
      default: return '0;
    endcase
  endfunction

  logic               tick;
  drive_state_e       state_q, state_d, target_q, target_d;
  logic [TIMER_W-1:0] timer_q, timer_d, stale_q, stale_d;
  logic               last_clear_q, last_clear_d;
  logic               run_q, run_d, dir1_q, dir1_d, dir2_q, dir2_d;
  logic               near_rd, clear_rd, expiry, reload, stale_hit;

  ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .iCLK  (iCLK),
    .iRST_n(iRST_n),
    .oTick (tick)
  );

  assign near_rd   = iDistValid && (iDistance <  DIST_W'(NEAR_CM));
  assign clear_rd  = iDistValid && (iDistance >= DIST_W'(FAR_CM));
  assign expiry    = tick && (timer_q == TIMER_W'(1));
  assign stale_hit = (stale_q == StaleT);

  always_comb begin
    last_clear_d = last_clear_q;
    if (near_rd)       last_clear_d = 1'b0;
    else if (clear_rd) last_clear_d = 1'b1;

    stale_d = stale_q;
    if (iDistValid)              stale_d = '0;
    else if (tick && !stale_hit) stale_d = stale_q + 1'b1;
  end

  // A reading arriving on the expiry cycle is already folded into last_clear_d.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    reload   = 1'b0;
    if (!iEnable) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: state_d = StFwd;
        StFwd: begin
          if (near_rd) begin
            state_d  = StBrake;
            target_d = iTurnMode ? StTurn : StRev;
          end else if (stale_hit && !iDistValid) begin
            state_d = StStall;
          end
        end
        StBrake: if (expiry) state_d = target_q;
        StRev, StTurn: begin
          if (near_rd) begin
            reload = 1'b1;
          end else if (expiry) begin
            if (last_clear_d) begin
              state_d  = StBrake;
              target_d = StFwd;
            end else begin
              reload = 1'b1;
            end
          end
        end
        StStall: begin
          if (clear_rd) begin
            state_d = StFwd;
          end else if (near_rd) begin
            state_d  = StBrake;
            target_d = iTurnMode ? StTurn : StRev;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    if (state_d != state_q || reload)      timer_d = dwell(state_d);
    else if (tick && timer_q != '0)        timer_d = timer_q - 1'b1;
    else                                   timer_d = timer_q;

    run_d  = is_driving(state_d);
    dir1_d = dir1_q;
    dir2_d = dir2_q;
    case (state_d)
      StIdle, StFwd: begin dir1_d = 1'b1; dir2_d = 1'b1; end
      StRev:         begin dir1_d = 1'b0; dir2_d = 1'b0; end
      StTurn:        begin dir1_d = 1'b0; dir2_d = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q      <= StIdle;
      target_q     <= StFwd;
      timer_q      <= '0;
      stale_q      <= '0;
      last_clear_q <= 1'b0;
      run_q        <= 1'b0;
      dir1_q       <= 1'b1;
      dir2_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      timer_q      <= timer_d;
      stale_q      <= stale_d;
      last_clear_q <= last_clear_d;
      run_q        <= run_d;
      dir1_q       <= dir1_d;
      dir2_q       <= dir2_d;
    end
  end

  assign oDir1  = dir1_q;
  assign oDir2  = dir2_q;
  assign oRun   = run_q;
  assign oState = state_q;
  assign oStale = stale_hit;

endmodule
